// File: rtl/icache_refill_if.sv
// Core, icache and memory signals of the icache refill controller.
// master: the refill controller. slave: the core, icache and memory around it.
`timescale 1ns/1ps
interface icache_refill_if;
    logic        req_valid;
    logic [29:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [29:0] cache_addr;
    logic        cache_wen;
    logic [31:0] cache_wdata;
    logic        cache_is_hit;
    logic [31:0] cache_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;

    modport master (
        input  req_valid, req_addr, cache_is_hit, cache_rdata,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output req_ready, resp_valid, resp_data, resp_err,
               cache_addr, cache_wen, cache_wdata, mem_req_valid, mem_req_addr
    );

    modport slave (
        output req_valid, req_addr, cache_is_hit, cache_rdata,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  req_ready, resp_valid, resp_data, resp_err,
               cache_addr, cache_wen, cache_wdata, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_refill.sv
// Fetch-side refill controller for the direct-mapped icache, with memory timeout.
// Optional ICACHE_REFILL_PERF_EN adds hit/miss/error event counters.
`timescale 1ns/1ps
module icache_refill #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    icache_refill_if.master  bus
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      err_count
`endif
);
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [29:0]        addr_q;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               cnt_last;
    logic               req_ready_c, resp_valid_c, resp_err_c, cache_wen_c, mem_req_valid_c;
    logic [31:0]        resp_data_c;

    assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.req_valid)
                addr_q <= bus.req_addr;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        req_ready_c     = 1'b0;
        resp_valid_c    = 1'b0;
        resp_err_c      = 1'b0;
        resp_data_c     = '0;
        cache_wen_c     = 1'b0;
        mem_req_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (bus.cache_is_hit) begin
                    resp_valid_c = 1'b1;
                    resp_data_c  = bus.cache_rdata;
                    state_nxt    = IDLE;
                end else begin
                    state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid_c = 1'b1;
                if (bus.mem_req_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // A response landing on the timeout cycle still wins.
                if (bus.mem_resp_valid) begin
                    resp_valid_c = 1'b1;
                    state_nxt    = IDLE;
                    if (bus.mem_resp_err) begin
                        resp_err_c = 1'b1;
                    end else begin
                        cache_wen_c = 1'b1;
                        resp_data_c = bus.mem_resp_data;
                    end
                end else if (cnt_last) begin
                    resp_valid_c = 1'b1;
                    resp_err_c   = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = DRAIN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Swallow the late response so it never pairs with a newer request.
                if (bus.mem_resp_valid || cnt_last) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready     = req_ready_c & ~reset;
    assign bus.resp_valid    = resp_valid_c & ~reset;
    assign bus.resp_err      = resp_err_c & ~reset;
    assign bus.resp_data     = reset ? '0 : resp_data_c;
    assign bus.cache_addr    = addr_q;
    assign bus.cache_wen     = cache_wen_c & ~reset;
    assign bus.cache_wdata   = reset ? '0 : bus.mem_resp_data;
    assign bus.mem_req_valid = mem_req_valid_c & ~reset;
    assign bus.mem_req_addr  = {addr_q, 2'b00};

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            err_count  <= '0;
        end else begin
            if (state == LOOKUP && bus.cache_is_hit)  hit_count  <= hit_count + 32'd1;
            if (state == LOOKUP && !bus.cache_is_hit) miss_count <= miss_count + 32'd1;
            if (resp_valid_c && resp_err_c)           err_count  <= err_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill (TIMEOUT=4): directed misses, hit, backpressure,
// memory error, timeout with stale-response drain, and reset mid-miss.
`timescale 1ns/1ps
module tb_icache_refill;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    icache_refill_if bus ();
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] hit_count, miss_count, err_count;
`endif

    icache_refill #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_REFILL_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .err_count  (err_count)
`endif
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wen_seen = 0;
    logic prev_rv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.cache_wen) wen_seen++;
            if (bus.resp_valid) begin
                chk("resp_back_to_back", prev_rv, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data %0h err %0b with nothing expected",
                             bus.resp_data, bus.resp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_data", bus.resp_data, e.data);
                    chk("resp_err", bus.resp_err, e.err);
                end
            end
        end
        prev_rv = bus.resp_valid;
    end

    initial begin
        repeat (3000) @(posedge clock);
        $display("FAIL watchdog: bench did not finish within 3000 cycles");
        $fatal(1);
    end

    // Full miss: response arrives after lat silent MISS_WAIT cycles.
    task automatic do_miss(input logic [29:0] addr, input logic [31:0] byte_addr,
                           input logic [31:0] data, input int lat);
        chk("miss_req_ready", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.cache_is_hit = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b1;
        #1;
        chk("miss_mem_req_valid", bus.mem_req_valid, 1);
        chk("miss_mem_req_addr", bus.mem_req_addr, byte_addr);
        exp_q.push_back('{data: data, err: 1'b0});
        tick();
        bus.mem_req_ready = 1'b0;
        repeat (lat) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        #1;
        chk("miss_cache_wen", bus.cache_wen, 1);
        chk("miss_cache_wdata", bus.cache_wdata, data);
        chk("miss_cache_addr", bus.cache_addr, addr);
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid      = 1'b1;
        bus.req_addr       = 30'h3;
        bus.cache_is_hit   = 1'b0;
        bus.cache_rdata    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_ctrl_outs", {bus.resp_valid, bus.mem_req_valid, bus.cache_wen}, 0);
        chk("rst_cache_addr", bus.cache_addr, 0);
        bus.req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("idle_req_ready", bus.req_ready, 1);

        // Cold miss, response on the 3rd MISS_WAIT cycle.
        do_miss(30'h10, 32'h40, 32'hDEADBEEF, 2);

        // Hit: response in the cycle after acceptance.
        bus.req_valid = 1'b1;
        bus.req_addr  = 30'h10;
        exp_q.push_back('{data: 32'h13, err: 1'b0});
        tick();
        bus.req_valid    = 1'b0;
        bus.cache_is_hit = 1'b1;
        bus.cache_rdata  = 32'h13;
        #1;
        chk("hit_resp_valid", bus.resp_valid, 1);
        chk("hit_no_mem_req", bus.mem_req_valid, 0);
        tick();
        bus.cache_is_hit = 1'b0;
        chk("hit_back_idle", bus.req_ready, 1);

        // Backpressure on the request, then a memory error on the timeout cycle.
        bus.req_valid = 1'b1;
        bus.req_addr  = 30'h20;
        tick();
        bus.req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_mem_req_valid", bus.mem_req_valid, 1);
            chk("bp_mem_req_addr", bus.mem_req_addr, 32'h80);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        repeat (3) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_err   = 1'b1;
        bus.mem_resp_data  = 32'h12345678;
        exp_q.push_back('{data: 32'h0, err: 1'b1});
        #1;
        chk("err_no_cache_wen", bus.cache_wen, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        #1;
        chk("err_back_idle", bus.req_ready, 1);

        // Timeout on the 4th MISS_WAIT cycle, stale response discarded in DRAIN.
        bus.req_valid = 1'b1;
        bus.req_addr  = 30'h30;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        exp_q.push_back('{data: 32'h0, err: 1'b1});
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_not_early", bus.resp_valid, 0);
            tick();
        end
        #1;
        chk("to_resp_valid", bus.resp_valid, 1);
        tick();
        chk("drain_req_ready", bus.req_ready, 0);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0BAD0BAD;
        #1;
        chk("drain_no_wen", bus.cache_wen, 0);
        chk("drain_no_resp", bus.resp_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        do_miss(30'h30, 32'hC0, 32'hCAFEF00D, 0);

        // Reset during MISS_WAIT; a late response afterwards is ignored.
        bus.req_valid = 1'b1;
        bus.req_addr  = 30'h40;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_hits", hit_count, 1);
        chk("perf_misses", miss_count, 5);
        chk("perf_errs", err_count, 2);
`endif
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {bus.req_ready, bus.resp_valid, bus.mem_req_valid, bus.cache_wen}, 0);
        chk("mid_rst_cache_addr", bus.cache_addr, 0);
        tick();
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h55AA55AA;
        #1;
        chk("late_no_wen", bus.cache_wen, 0);
        chk("late_no_resp", bus.resp_valid, 0);
        chk("late_idle", bus.req_ready, 1);
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_rst", {hit_count, miss_count} | {32'h0, err_count}, 0);
`endif
        tick();
        bus.mem_resp_valid = 1'b0;
        repeat (2) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("cache_wen_total", wen_seen, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Fetch-side controller in front of the 16-line direct-mapped icache.
- Accepts word fetch requests from the core and probes the cache.
- On a hit, returns the cached word.
- On a miss, issues a single-word read to memory over a valid/ready handshake, writes the returned word into the cache, and forwards it to the core.
- A memory-response timeout converts hung reads into error responses.

Parameters:
- TIMEOUT, 255: max cycles waited in MISS_WAIT before declaring an error; legal range 1..65535.
- CNT_W, 16: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  1  core fetch request
- req_addr  input  30  word address [31:2]
- req_ready  output  1  block can accept a request
- resp_valid  output  1  one-cycle response pulse; core always accepts
- resp_data  output  32  instruction word, valid with resp_valid
- resp_err  output  1  response is an error (timeout or memory error); resp_data=0
- cache_addr  output  30  address to icache (lookup and fill)
- cache_wen  output  1  icache fill strobe
- cache_wdata  output  32  icache fill data
- cache_is_hit  input  1  icache hit for cache_addr
- cache_rdata  input  32  icache data for cache_addr
- mem_req_valid  output  1  memory read request
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  byte address {addr_q, 2'b00}
- mem_resp_valid  input  1  memory read data valid
- mem_resp_data  input  32  memory read data
- mem_resp_err  input  1  memory read error, qualified by mem_resp_valid

Behaviour:
- State register: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, DRAIN. Reset -> IDLE, addr_q=0, cnt=0.
- While reset is high, all outputs are 0, including req_ready.
- cache_addr = addr_q in all states. cache_wdata = mem_resp_data.
- IDLE:
  - req_ready=1.
  - req_valid -> addr_q<=req_addr, go LOOKUP.
- LOOKUP:
  - cache_is_hit=1 -> resp_valid=1, resp_data=cache_rdata, resp_err=0, go IDLE. Hit latency: response in the cycle after acceptance.
  - Otherwise go MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, held with mem_req_addr stable until mem_req_ready.
  - On handshake: cnt<=0, go MISS_WAIT.
  - No timeout applies in this state.
- MISS_WAIT, evaluated each cycle:
  - mem_resp_valid & !mem_resp_err -> cache_wen=1, resp_valid=1, resp_data=mem_resp_data, go IDLE.
  - mem_resp_valid & mem_resp_err -> resp_valid=1, resp_err=1, resp_data=0, cache_wen=0, go IDLE.
  - Else cnt==TIMEOUT-1 -> resp_valid=1, resp_err=1, resp_data=0, cnt<=0, go DRAIN.
  - Else cnt<=cnt+1.
  - A response in the same cycle as the timeout has priority over the timeout.
- DRAIN:
  - req_ready=0. Waits for the stale memory response, which is discarded (no cache write, no resp_valid).
  - On mem_resp_valid, or after a further TIMEOUT cycles, go IDLE.
  - Guarantees a late response is never matched to a later request.
- mem_resp_valid outside MISS_WAIT/DRAIN is ignored.
- Outputs other than addr_q-derived signals are combinational from state and inputs. resp_valid is never asserted for two consecutive cycles.
- Reset mid-operation: return to IDLE immediately; any outstanding memory transaction is abandoned. Memory-side reset is shared, so it is abandoned there too.
- Back-to-back: after a response the block is in IDLE and can accept the next request that cycle. Minimum hit throughput is one request per 2 cycles.

Optional Feature:
- ICACHE_REFILL_PERF_EN: adds outputs hit_count[31:0], miss_count[31:0], err_count[31:0]. Each is reset to 0 and incremented respectively on:
  - hit response (LOOKUP hit),
  - LOOKUP miss,
  - any resp_err pulse.
- Counters wrap at 2**32.
- Without the macro these ports and registers do not exist; core behaviour is identical.

Test Plan:
- Cold miss: req 0x0000_0010 (word addr), cache miss, mem_req_ready=1 immediately, mem_resp 0xDEADBEEF after 3 cycles -> mem_req_addr=0x0000_0040, cache_wen pulse with 0xDEADBEEF, resp_valid with 0xDEADBEEF, resp_err=0.
- Hit: cache returns is_hit=1, rdata=0x00000013 for the same addr -> resp_valid in the cycle after acceptance, data 0x00000013, no mem_req_valid.
- Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr held stable 5 cycles; timeout counter does not advance.
- Memory error: mem_resp_err=1 -> resp_err=1, resp_data=0, cache_wen never asserted.
- Timeout: TIMEOUT=4, no mem response -> resp_err on the 4th MISS_WAIT cycle. A stale response 2 cycles later is discarded in DRAIN; the next request is served correctly.
- Reset during MISS_WAIT -> outputs 0 and state IDLE. A late mem_resp_valid after reset causes no cache_wen and no resp_valid. With ICACHE_REFILL_PERF_EN, counters read 0.
